// File: rtl/harzbus_slot_bridge_if.sv
// Host request bundle and slot bus between Pico decoder and slot devices.
// slave: bridge side (takes requests, drives slot bus); master: environment side.
interface harzbus_slot_bridge_if;
  logic [3:0]  req;
  logic [15:0] req_address;
  logic [7:0]  req_write_data;
  logic [7:0]  req_read_data;
  logic        req_busy;
  logic        slot_clock;
  logic        slot_reset_n;
  logic        slot_iorq;
  logic        slot_merq;
  logic        slot_wr;
  logic        slot_rd;
  logic [15:0] slot_a;
  logic [7:0]  slot_write_d;
  logic [7:0]  slot_read_d;
  logic        slot_busy;
  logic        err_timeout;

  modport slave (
    input  req, req_address, req_write_data,
    input  slot_read_d, slot_busy,
    output req_read_data, req_busy,
    output slot_clock, slot_reset_n,
    output slot_iorq, slot_merq, slot_wr, slot_rd,
    output slot_a, slot_write_d, err_timeout
  );

  modport master (
    output req, req_address, req_write_data,
    output slot_read_d, slot_busy,
    input  req_read_data, req_busy,
    input  slot_clock, slot_reset_n,
    input  slot_iorq, slot_merq, slot_wr, slot_rd,
    input  slot_a, slot_write_d, err_timeout
  );
endinterface

// File: rtl/harzbus_slot_bridge.sv
// Turns single-byte harzbus requests into timed slot bus cycles.
// Ports: clk, reset (async, active high), bus (slave modport: req + slot bus).
module harzbus_slot_bridge #(
  parameter int unsigned CLK_DIV        = 3,
  parameter int unsigned RESET_HOLD     = 16,
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter int unsigned HOLD_CYCLES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input logic clk,
  input logic reset,
  harzbus_slot_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_HOLD, S_DONE
  } state_t;

  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [15:0] RST_LAST   = 16'(RESET_HOLD - 1);
  localparam logic [7:0]  SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0]  STB_LAST   = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [7:0]  phase_cnt;
  logic [15:0] rst_cnt;
  logic [15:0] wait_cnt;
  logic        sclk_q;
  logic        srst_n_q;
  logic        iorq_q, merq_q, wr_q, rd_q;
  logic        busy_q, err_q, op_rd;
  logic [15:0] a_q;
  logic [7:0]  wd_q, rdata_q;
  logic        req_ok, req_rd, req_io;

  assign req_ok = (bus.req >= 4'd1) && (bus.req <= 4'd4);
  assign req_rd = (bus.req == 4'd2) || (bus.req == 4'd4);
  assign req_io = (bus.req == 4'd1) || (bus.req == 4'd2);

  // Free-running slot clock, independent of cycle state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= 8'd0;
      sclk_q  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= 8'd0;
      sclk_q  <= ~sclk_q;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Slot reset stretcher; also gates request acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_cnt  <= 16'd0;
      srst_n_q <= 1'b0;
    end else if (!srst_n_q) begin
      if (rst_cnt == RST_LAST) srst_n_q <= 1'b1;
      else rst_cnt <= rst_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_cnt <= 8'd0;
      wait_cnt  <= 16'd0;
      iorq_q    <= 1'b0;
      merq_q    <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      op_rd     <= 1'b0;
      a_q       <= 16'd0;
      wd_q      <= 8'd0;
      rdata_q   <= 8'hFF;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (srst_n_q && req_ok) begin
            op_rd     <= req_rd;
            a_q       <= bus.req_address;
            wd_q      <= bus.req_write_data;
            iorq_q    <= req_io;
            merq_q    <= ~req_io;
            busy_q    <= 1'b1;
            phase_cnt <= SETUP_LAST;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (phase_cnt != 8'd0) begin
            phase_cnt <= phase_cnt - 8'd1;
          end else begin
            wr_q      <= ~op_rd;
            rd_q      <= op_rd;
            phase_cnt <= STB_LAST;
            state     <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (phase_cnt != 8'd0) begin
            phase_cnt <= phase_cnt - 8'd1;
          end else if (!bus.slot_busy) begin
            if (op_rd) rdata_q <= bus.slot_read_d;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            phase_cnt <= HOLD_LAST;
            state     <= S_HOLD;
          end else begin
            wait_cnt <= 16'd0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.slot_busy) begin
            if (op_rd) rdata_q <= bus.slot_read_d;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            phase_cnt <= HOLD_LAST;
            state     <= S_HOLD;
          end else if (wait_cnt == TO_LAST) begin
            if (op_rd) rdata_q <= 8'hFF;
            err_q     <= 1'b1;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            phase_cnt <= HOLD_LAST;
            state     <= S_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_HOLD: begin
          if (phase_cnt != 8'd0) begin
            phase_cnt <= phase_cnt - 8'd1;
          end else begin
            iorq_q <= 1'b0;
            merq_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          // One-shot: a held request must drop to NONE first.
          if (bus.req == 4'd0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_read_data = rdata_q;
  assign bus.req_busy      = busy_q;
  assign bus.slot_clock    = sclk_q;
  assign bus.slot_reset_n  = srst_n_q;
  assign bus.slot_iorq     = iorq_q;
  assign bus.slot_merq     = merq_q;
  assign bus.slot_wr       = wr_q;
  assign bus.slot_rd       = rd_q;
  assign bus.slot_a        = a_q;
  assign bus.slot_write_d  = wd_q;
  assign bus.err_timeout   = err_q;

endmodule

// File: tb/tb_harzbus_slot_bridge.sv
// Directed bench for harzbus_slot_bridge: vector table plus corner sequences.
// Uses TIMEOUT_CYCLES=8 so the stuck-busy case finishes quickly.
module tb_harzbus_slot_bridge;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  harzbus_slot_bridge_if bus();

  harzbus_slot_bridge #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rdin;
    logic        sbusy;
    logic        e_busy;
    logic        e_iorq;
    logic        e_merq;
    logic        e_wr;
    logic        e_rd;
    logic [15:0] e_a;
    logic [7:0]  e_wd;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reset released just after an edge; request held during the hold window.
  task automatic reset_window();
    reset = 1'b0;
    bus.req = 4'd1;
    bus.req_address = 16'h0042;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("win_busy", 32'(bus.req_busy), 32'd0);
      chk("win_iorq", 32'(bus.slot_iorq), 32'd0);
    end
    chk("rstn_low15", 32'(bus.slot_reset_n), 32'd0);
    bus.req = 4'd0;
    tick();
    chk("rstn_high16", 32'(bus.slot_reset_n), 32'd1);
    tick();
    chk("win_ignored", 32'(bus.req_busy), 32'd0);
  endtask

  initial begin
    int cnt;
    int errs;
    int rises;
    logic prev;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.req = 4'd0;
    bus.req_address = 16'd0;
    bus.req_write_data = 8'd0;
    bus.slot_read_d = 8'd0;
    bus.slot_busy = 1'b0;

    vecs[0]  = '{4'd1, 16'h00A0, 8'h07, 8'h00, 1'b0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00A0, 8'h07, 8'hFF};
    vecs[1]  = '{4'd0, 16'h1234, 8'hEE, 8'h00, 1'b0,
                 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00A0, 8'h07, 8'hFF};
    vecs[2]  = '{4'd0, 16'h1234, 8'hEE, 8'h00, 1'b0,
                 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00A0, 8'h07, 8'hFF};
    vecs[3]  = '{4'd0, 16'h1234, 8'hEE, 8'h00, 1'b0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00A0, 8'h07, 8'hFF};
    vecs[4]  = '{4'd0, 16'h1234, 8'hEE, 8'h00, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00A0, 8'h07, 8'hFF};
    vecs[5]  = '{4'd0, 16'h1234, 8'hEE, 8'h00, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00A0, 8'h07, 8'hFF};
    vecs[6]  = '{4'd4, 16'h9800, 8'h33, 8'h5A, 1'b0,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h9800, 8'h33, 8'hFF};
    vecs[7]  = '{4'd4, 16'h9800, 8'h33, 8'h5A, 1'b0,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h9800, 8'h33, 8'hFF};
    vecs[8]  = '{4'd4, 16'h9800, 8'h33, 8'h5A, 1'b0,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h9800, 8'h33, 8'hFF};
    vecs[9]  = '{4'd4, 16'h9800, 8'h33, 8'h5A, 1'b0,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h9800, 8'h33, 8'h5A};
    vecs[10] = '{4'd4, 16'h9800, 8'h33, 8'h5A, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9800, 8'h33, 8'h5A};
    vecs[11] = '{4'd4, 16'h9800, 8'h33, 8'h5A, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9800, 8'h33, 8'h5A};

    // Reset values.
    tick();
    tick();
    chk("rst_rdata", 32'(bus.req_read_data), 32'hFF);
    chk("rst_busy", 32'(bus.req_busy), 32'd0);
    chk("rst_sclk", 32'(bus.slot_clock), 32'd0);
    chk("rst_rstn", 32'(bus.slot_reset_n), 32'd0);
    chk("rst_strb", 32'({bus.slot_iorq, bus.slot_merq,
                         bus.slot_wr, bus.slot_rd}), 32'd0);
    chk("rst_a", 32'(bus.slot_a), 32'd0);
    chk("rst_wd", 32'(bus.slot_write_d), 32'd0);
    chk("rst_err", 32'(bus.err_timeout), 32'd0);

    reset_window();

    // Slot clock: 10 toggles in any 30 consecutive clk cycles.
    cnt = 0;
    prev = bus.slot_clock;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.slot_clock !== prev) cnt++;
      prev = bus.slot_clock;
    end
    chk("sclk_toggles", 32'(cnt), 32'd10);

    // IO_WRITE and MEM_READ_1 cycle by cycle.
    for (int i = 0; i < 12; i++) begin
      bus.req = vecs[i].req;
      bus.req_address = vecs[i].addr;
      bus.req_write_data = vecs[i].wd;
      bus.slot_read_d = vecs[i].rdin;
      bus.slot_busy = vecs[i].sbusy;
      tick();
      chk($sformatf("v%0d_busy", i), 32'(bus.req_busy),
          32'(vecs[i].e_busy));
      chk($sformatf("v%0d_iorq", i), 32'(bus.slot_iorq),
          32'(vecs[i].e_iorq));
      chk($sformatf("v%0d_merq", i), 32'(bus.slot_merq),
          32'(vecs[i].e_merq));
      chk($sformatf("v%0d_wr", i), 32'(bus.slot_wr),
          32'(vecs[i].e_wr));
      chk($sformatf("v%0d_rd", i), 32'(bus.slot_rd),
          32'(vecs[i].e_rd));
      chk($sformatf("v%0d_a", i), 32'(bus.slot_a),
          32'(vecs[i].e_a));
      chk($sformatf("v%0d_wd", i), 32'(bus.slot_write_d),
          32'(vecs[i].e_wd));
      chk($sformatf("v%0d_rdata", i), 32'(bus.req_read_data),
          32'(vecs[i].e_rdata));
    end
    bus.req = 4'd0;
    tick();

    // IO_READ with busy extending the strobe by 5 cycles.
    bus.req = 4'd2;
    bus.req_address = 16'h0055;
    bus.slot_read_d = 8'h11;
    bus.slot_busy = 1'b1;
    tick();
    bus.req = 4'd0;
    cnt = 0;
    errs = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 8) begin
        bus.slot_busy = 1'b0;
        bus.slot_read_d = 8'h3C;
      end
      tick();
      if (bus.slot_rd) cnt++;
      if (bus.err_timeout) errs++;
    end
    chk("wait_rd_width", 32'(cnt), 32'd7);
    chk("wait_rdata", 32'(bus.req_read_data), 32'h3C);
    chk("wait_no_err", 32'(errs), 32'd0);
    chk("wait_a", 32'(bus.slot_a), 32'h0055);
    chk("wait_busy_end", 32'(bus.req_busy), 32'd0);

    // IO_READ with busy stuck: timeout after 8 wait cycles.
    bus.req = 4'd2;
    bus.req_address = 16'h0066;
    bus.slot_read_d = 8'h77;
    bus.slot_busy = 1'b1;
    tick();
    bus.req = 4'd0;
    cnt = 0;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.slot_rd) cnt++;
      if (bus.err_timeout) errs++;
    end
    chk("to_err_pulses", 32'(errs), 32'd1);
    chk("to_rd_width", 32'(cnt), 32'd10);
    chk("to_rdata", 32'(bus.req_read_data), 32'hFF);
    chk("to_busy_end", 32'(bus.req_busy), 32'd0);
    bus.slot_busy = 1'b0;

    // Held request runs once; drop for one cycle to rerun.
    bus.req = 4'd1;
    bus.req_address = 16'h0010;
    bus.req_write_data = 8'hA5;
    rises = 0;
    prev = bus.slot_iorq;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.slot_iorq && !prev) rises++;
      prev = bus.slot_iorq;
    end
    chk("held_once", 32'(rises), 32'd1);
    bus.req = 4'd0;
    tick();
    bus.req = 4'd1;
    rises = 0;
    prev = bus.slot_iorq;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.slot_iorq && !prev) rises++;
      prev = bus.slot_iorq;
    end
    chk("rearm_once", 32'(rises), 32'd1);
    bus.req = 4'd0;
    tick();

    // Reset asserted while wr is high.
    bus.req = 4'd3;
    bus.req_address = 16'h1234;
    bus.req_write_data = 8'h99;
    tick();
    bus.req = 4'd0;
    tick();
    chk("strb_wr_on", 32'(bus.slot_wr), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_wr", 32'(bus.slot_wr), 32'd0);
    chk("async_merq", 32'(bus.slot_merq), 32'd0);
    chk("async_busy", 32'(bus.req_busy), 32'd0);
    chk("async_rstn", 32'(bus.slot_reset_n), 32'd0);
    tick();
    tick();
    reset_window();

    // Invalid code 7 never starts a cycle.
    bus.req = 4'd7;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.req_busy || bus.slot_iorq || bus.slot_merq) cnt++;
    end
    chk("code7_ignored", 32'(cnt), 32'd0);
    bus.req = 4'd0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/harzbus_slot_bridge.md
Name: harzbus_slot_bridge

Overview:
- Host side of harzbus_if: accepts single-byte I/O and memory requests from the Pico command decoder.
- Converts each request into one timed cycle on msxslotbus_if (client side), which feeds the sound-chip slot devices.
- Generates the slot clock and the slot reset, honours slot busy (wait) with a timeout, and returns read data.

Parameters:
- CLK_DIV, 3: slot_clock half-period in clk cycles (1..255).
- RESET_HOLD, 16: clk cycles slot_reset_n stays low after reset release (1..65535).
- SETUP_CYCLES, 1: address/iorq/merq valid before rd/wr asserts (1..255).
- STROBE_CYCLES, 2: minimum rd/wr width (1..255).
- HOLD_CYCLES, 1: address/iorq/merq held after rd/wr deasserts (1..255).
- TIMEOUT_CYCLES, 1023: maximum clk cycles waiting on slot_busy (1..65535).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active high.
- req  in  4  harz_req_t: 0 NONE, 1 IO_WRITE, 2 IO_READ, 3 MEM_WRITE_1, 4 MEM_READ_1.
- req_address  in  16  request address.
- req_write_data  in  8  request write byte.
- req_read_data  out  8  read result.
- req_busy  out  1  request in progress.
- slot_clock  out  1  divided slot clock.
- slot_reset_n  out  1  slot reset, active low.
- slot_iorq, slot_merq, slot_wr, slot_rd  out  1 each  active-high strobes.
- slot_a  out  16  slot address.
- slot_write_d  out  8  slot write data.
- slot_read_d  in  8  slot read data.
- slot_busy  in  1  slot wait request.
- err_timeout  out  1  one-cycle pulse on a timeout.

Behaviour:
- Reset values: req_read_data 8'hFF, req_busy 0, slot_clock 0, slot_reset_n 0, all strobes 0, slot_a 0, slot_write_d 0, err_timeout 0. State is IDLE.
- Reset asserted mid-cycle: strobes drop immediately (asynchronously) and no partial cycle is resumed.
- Slot clock: slot_clock toggles every CLK_DIV clk cycles. It runs free and independently of the cycle FSM.
- Slot reset: slot_reset_n releases high after RESET_HOLD clk cycles following reset deassertion. Requests are ignored (stay in IDLE) until then.
- Requests are sampled on the clk rising edge. All outputs are registered.
- IDLE: req_busy=0. If req is 1..4, latch req, req_address and req_write_data. Set req_busy=1, drive slot_a and slot_write_d, assert iorq (codes 1,2) or merq (codes 3,4), then go to SETUP. Codes 0 and 5..15 are ignored.
- SETUP: lasts SETUP_CYCLES. Then assert wr (codes 1,3) or rd (codes 2,4) and go to STROBE.
- STROBE: lasts STROBE_CYCLES. At the last cycle, if slot_busy=0, capture slot_read_d for reads, drop rd/wr and go to HOLD. Otherwise go to WAIT.
- WAIT: rd/wr stay asserted and a timeout counter counts.
  - slot_busy falls: capture slot_read_d for reads, drop rd/wr, go to HOLD.
  - Counter reaches TIMEOUT_CYCLES: set req_read_data=8'hFF for reads, pulse err_timeout, drop rd/wr, go to HOLD.
- HOLD: lasts HOLD_CYCLES. Then drop iorq/merq, set req_busy=0 and go to DONE.
- DONE: req_busy=0. Wait until req==NONE, then go to IDLE. This is the one-shot rule: a request held high is never executed twice.
- req_read_data updates only on read completion. Writes do not change it.
- Inputs latched in IDLE are used for the whole cycle, so changes to req_address and req_write_data during busy have no effect.
- Only one of iorq/merq and only one of rd/wr is ever high. rd/wr are high only while iorq/merq are high.
- Default latency with no wait: req_busy is high for SETUP+STROBE+HOLD = 4 clk cycles.

Test Plan:
- IO_WRITE addr 16'h00A0, data 8'h07, slot_busy=0, defaults -> iorq high 4 cycles, wr high cycles 2-3, slot_a=16'h00A0, slot_write_d=8'h07, req_busy high 4 cycles, then 0.
- MEM_READ_1 addr 16'h9800, slot_read_d=8'h5A -> merq/rd strobe sequence as above, req_read_data=8'h5A after busy falls, iorq never high.
- IO_READ with slot_busy held high 5 cycles after the strobe minimum -> rd width 7 cycles, data captured at busy fall, err_timeout stays 0.
- IO_READ with TIMEOUT_CYCLES=8 and slot_busy stuck high -> err_timeout pulses once, req_read_data=8'hFF, FSM returns via HOLD/DONE.
- IO_WRITE request held high 20 cycles -> exactly one slot cycle. Dropping to NONE for 1 cycle and reasserting -> a second cycle.
- reset asserted during STROBE -> strobes 0 asynchronously, slot_reset_n low for 16 cycles after release, a req during that window is ignored. Code 4'h7 is never executed.
